msa_fine_tracker: RTL

//  Clocked successor to the MSA fine-error path: digitised MSA error in, hysteretic
//  TLF1/TLF2 detection, rate-selected up/down stepping of the read counter, ladder

---
 rtl/msa_pkg.sv | 52 +++++
 rtl/msa_pulse_queue.sv | 88 ++++++++
 rtl/msa_fine_tracker.sv | 139 +++++++++++++
 3 files changed

// File: rtl/msa_pkg.sv
// Shared types and default constants for the MSA fine-error tracker.
// The threshold/divider defaults are also used by the MSA ADC model.
package msa_pkg;

  typedef enum logic [1:0] {
    NULL_S = 2'd0,
    SLOW_S = 2'd1,
    FAST_S = 2'd2
  } trk_state_t;

  localparam int ERR_W_D       = 12;
  localparam int CNT_W_D       = 16;
  localparam int LADDER_BITS_D = 7;
  localparam int LO_ON_D       = 40;
  localparam int LO_OFF_D      = 30;
  localparam int HI_ON_D       = 680;
  localparam int HI_OFF_D      = 600;
  localparam int SLOW_DIV_D    = 64;
  localparam int FAST_DIV_D    = 4;
  localparam int SETTLE_CYC_D  = 8;
  localparam int PEND_MAX_D    = 15;

  // Hysteretic tracking-state transition, fed by precomputed magnitude compares.
  function automatic trk_state_t next_state(input trk_state_t cur,
                                            input logic       ge_lo_on,
                                            input logic       lt_lo_off,
                                            input logic       ge_hi_on,
                                            input logic       lt_hi_off);
    trk_state_t nxt;
    nxt = cur;
    case (cur)
      NULL_S: begin
        if (ge_hi_on)      nxt = FAST_S;
        else if (ge_lo_on) nxt = SLOW_S;
        else               nxt = NULL_S;
      end
      SLOW_S: begin
        if (ge_hi_on)       nxt = FAST_S;
        else if (lt_lo_off) nxt = NULL_S;
        else                nxt = SLOW_S;
      end
      FAST_S: begin
        if (lt_lo_off)      nxt = NULL_S;
        else if (lt_hi_off) nxt = SLOW_S;
        else                nxt = FAST_S;
      end
      default: nxt = NULL_S;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/msa_pulse_queue.sv
// Saturating signed pending-pulse counter with a valid/ready drain port.
// Positive pending means up-pulses owed downstream, negative means down-pulses.
module msa_pulse_queue
  import msa_pkg::*;
#(
  parameter int PEND_MAX = PEND_MAX_D
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic step,
  input  logic step_up,
  input  logic pulse_ready,
  output logic pulse_valid,
  output logic pulse_dir,
  output logic pend_ovf
);

  localparam int PEND_W = $clog2(PEND_MAX + 1) + 1;
  localparam logic signed [PEND_W-1:0] PMAX_P = PEND_W'(PEND_MAX);
  localparam logic signed [PEND_W-1:0] PMAX_N = -PMAX_P;
  localparam logic signed [PEND_W-1:0] ONE_P  = PEND_W'(1);
  localparam logic signed [PEND_W-1:0] ZERO_P = {PEND_W{1'b0}};

  logic signed [PEND_W-1:0] pend_r;
  logic signed [PEND_W-1:0] base_s;
  logic signed [PEND_W-1:0] next_s;
  logic                     ovf_set_s;
  logic                     valid_r;
  logic                     dir_r;
  logic                     ovf_r;

  // Net effect of an accepted pulse and a new step in the same cycle.
  always_comb begin
    base_s    = pend_r;
    next_s    = pend_r;
    ovf_set_s = 1'b0;
    if (valid_r && pulse_ready) begin
      if (pend_r[PEND_W-1]) base_s = pend_r + ONE_P;
      else                  base_s = pend_r - ONE_P;
    end else begin
      base_s = pend_r;
    end
    if (step) begin
      if (step_up) begin
        if (base_s == PMAX_P) begin
          next_s    = base_s;
          ovf_set_s = 1'b1;
        end else begin
          next_s = base_s + ONE_P;
        end
      end else begin
        if (base_s == PMAX_N) begin
          next_s    = base_s;
          ovf_set_s = 1'b1;
        end else begin
          next_s = base_s - ONE_P;
        end
      end
    end else begin
      next_s = base_s;
    end
  end

  // Pending count and its registered handshake view; overflow flag is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r  <= ZERO_P;
      valid_r <= 1'b0;
      dir_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (clear) begin
      pend_r  <= ZERO_P;
      valid_r <= 1'b0;
      dir_r   <= 1'b0;
    end else begin
      pend_r  <= next_s;
      valid_r <= (next_s != ZERO_P);
      dir_r   <= (!next_s[PEND_W-1]) && (next_s != ZERO_P);
      ovf_r   <= ovf_r | ovf_set_s;
    end
  end

  assign pulse_valid = valid_r;
  assign pulse_dir   = dir_r;
  assign pend_ovf    = ovf_r;

endmodule

// File: rtl/msa_fine_tracker.sv
// Clocked MSA fine-error tracker: hysteretic NULL/SLOW/FAST detection,
// rate-divided stepping of the read counter with post-step settling,
// active-low ladder drive and a handshaked count-pulse stream.
module msa_fine_tracker
  import msa_pkg::*;
#(
  parameter int ERR_W       = ERR_W_D,
  parameter int CNT_W       = CNT_W_D,
  parameter int LADDER_BITS = LADDER_BITS_D,
  parameter int LO_ON       = LO_ON_D,
  parameter int LO_OFF      = LO_OFF_D,
  parameter int HI_ON       = HI_ON_D,
  parameter int HI_OFF      = HI_OFF_D,
  parameter int SLOW_DIV    = SLOW_DIV_D,
  parameter int FAST_DIV    = FAST_DIV_D,
  parameter int SETTLE_CYC  = SETTLE_CYC_D,
  parameter int PEND_MAX    = PEND_MAX_D
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [ERR_W-1:0] err,
  input  logic                    zero_cmd,
  output logic [CNT_W-1:0]        cnt,
  output logic [LADDER_BITS-1:0]  ladder_n,
  output logic                    tlf1,
  output logic                    tlf2,
  output logic                    pulse_valid,
  output logic                    pulse_dir,
  input  logic                    pulse_ready,
  output logic                    pend_ovf
);

  localparam int MAG_W  = ERR_W - 1;
  localparam int RATE_W = (SLOW_DIV > FAST_DIV) ? $clog2(SLOW_DIV) : $clog2(FAST_DIV);
  localparam int SET_W  = $clog2(SETTLE_CYC + 1);

  localparam logic [MAG_W-1:0]  LO_ON_M    = MAG_W'(LO_ON);
  localparam logic [MAG_W-1:0]  LO_OFF_M   = MAG_W'(LO_OFF);
  localparam logic [MAG_W-1:0]  HI_ON_M    = MAG_W'(HI_ON);
  localparam logic [MAG_W-1:0]  HI_OFF_M   = MAG_W'(HI_OFF);
  localparam logic [MAG_W-1:0]  MAG_ONE    = MAG_W'(1);
  localparam logic [RATE_W-1:0] SLOW_LAST  = RATE_W'(SLOW_DIV - 1);
  localparam logic [RATE_W-1:0] FAST_LAST  = RATE_W'(FAST_DIV - 1);
  localparam logic [RATE_W-1:0] RATE_ONE   = RATE_W'(1);
  localparam logic [SET_W-1:0]  SET_LOAD   = SET_W'(SETTLE_CYC);
  localparam logic [SET_W-1:0]  SET_ONE    = SET_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  trk_state_t             state_r;
  trk_state_t             next_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [RATE_W-1:0]      rate_r;
  logic [RATE_W-1:0]      div_last_s;
  logic [SET_W-1:0]       settle_r;
  logic [LADDER_BITS-1:0] ladder_r;
  logic [MAG_W-1:0]       mag_s;
  logic                   tlf1_r;
  logic                   tlf2_r;
  logic                   step_s;
  logic                   step_up_s;

  // |err|, with the most negative code clamped to the largest positive magnitude.
  always_comb begin
    mag_s = err[MAG_W-1:0];
    if (err[ERR_W-1]) begin
      if (err[MAG_W-1:0] == {MAG_W{1'b0}}) mag_s = {MAG_W{1'b1}};
      else                                 mag_s = ~err[MAG_W-1:0] + MAG_ONE;
    end else begin
      mag_s = err[MAG_W-1:0];
    end
  end

  // Candidate next state and the rate-counter terminal value for the current state.
  always_comb begin
    next_s = next_state(state_r, (mag_s >= LO_ON_M), (mag_s < LO_OFF_M),
                        (mag_s >= HI_ON_M), (mag_s < HI_OFF_M));
    if (state_r == FAST_S) div_last_s = FAST_LAST;
    else                   div_last_s = SLOW_LAST;
  end

  // A step happens only when settled, the state holds, and the divider has expired.
  assign step_s = !rst && !zero_cmd && (settle_r == {SET_W{1'b0}}) &&
                  (next_s == state_r) && (state_r != NULL_S) && (rate_r == div_last_s);
  assign step_up_s = ~err[ERR_W-1];

  // Tracking state, rate divider, settle timer, read counter and threshold flags.
  always_ff @(posedge clk) begin
    if (rst || zero_cmd) begin
      state_r  <= NULL_S;
      cnt_r    <= {CNT_W{1'b0}};
      rate_r   <= {RATE_W{1'b0}};
      settle_r <= {SET_W{1'b0}};
      tlf1_r   <= 1'b0;
      tlf2_r   <= 1'b0;
    end else if (settle_r != {SET_W{1'b0}}) begin
      settle_r <= settle_r - SET_ONE;
    end else if (next_s != state_r) begin
      state_r <= next_s;
      rate_r  <= {RATE_W{1'b0}};
      tlf1_r  <= (next_s != NULL_S);
      tlf2_r  <= (next_s == FAST_S);
    end else if (step_s) begin
      if (step_up_s) cnt_r <= cnt_r + CNT_ONE;
      else           cnt_r <= cnt_r - CNT_ONE;
      rate_r   <= {RATE_W{1'b0}};
      settle_r <= SET_LOAD;
    end else if (state_r != NULL_S) begin
      rate_r <= rate_r + RATE_ONE;
    end else begin
      rate_r <= {RATE_W{1'b0}};
    end
  end

  // Ladder switches are active-low copies of the counter LSBs, one cycle behind.
  always_ff @(posedge clk) begin
    if (rst) ladder_r <= {LADDER_BITS{1'b1}};
    else     ladder_r <= ~cnt_r[LADDER_BITS-1:0];
  end

  msa_pulse_queue #(
    .PEND_MAX(PEND_MAX)
  ) u_pulse_queue (
    .clk        (clk),
    .rst        (rst),
    .clear      (zero_cmd),
    .step       (step_s),
    .step_up    (step_up_s),
    .pulse_ready(pulse_ready),
    .pulse_valid(pulse_valid),
    .pulse_dir  (pulse_dir),
    .pend_ovf   (pend_ovf)
  );

  assign cnt      = cnt_r;
  assign ladder_n = ladder_r;
  assign tlf1     = tlf1_r;
  assign tlf2     = tlf2_r;

endmodule
